// File: rtl/shift_seq_16b_if.sv
// Handshake and shifter-port bundle for the 16-bit shift sequencer.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface shift_seq_16b_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic [15:0] sh_a;
  logic [3:0]  sh_sel;
  logic [1:0]  sh_lr;
  logic [15:0] sh_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_c;
  logic        out_z;
  logic        out_n;
  logic        out_err;

  modport slave (
    input  in_valid, in_a, in_amt, in_op, sh_b, out_ready,
    output in_ready, sh_a, sh_sel, sh_lr,
    output out_valid, out_data, out_c, out_z, out_n, out_err
  );

  modport master (
    output in_valid, in_a, in_amt, in_op, sh_b, out_ready,
    input  in_ready, sh_a, sh_sel, sh_lr,
    input  out_valid, out_data, out_c, out_z, out_n, out_err
  );
endinterface

// File: rtl/shift_seq_16b.sv
// Multi-cycle shift/rotate sequencer driving an external combinational barrel shifter.
// Rotates take two shifter passes (one per direction) whose results are OR-ed together.
module shift_seq_16b (
  input  logic           clk,
  input  logic           rst_n,
  shift_seq_16b_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  localparam logic [1:0] LR_LL = 2'b00;
  localparam logic [1:0] LR_LR = 2'b10;
  localparam logic [1:0] LR_AR = 2'b11;

  function automatic logic [1:0] pass1_lr(input logic [2:0] op);
    logic [1:0] lr;
    case (op)
      OP_SLL:  lr = LR_LL;
      OP_SRL:  lr = LR_LR;
      OP_SRA:  lr = LR_AR;
      OP_ROL:  lr = LR_LL;
      OP_ROR:  lr = LR_LR;
      default: lr = LR_LL;
    endcase
    return lr;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [4:0]  amt_q, amt_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] partial_q, partial_d;
  logic [15:0] sh_a_q, sh_a_d;
  logic [3:0]  sh_sel_q, sh_sel_d;
  logic [1:0]  sh_lr_q, sh_lr_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_c_q, out_c_d;
  logic        out_z_q, out_z_d;
  logic        out_n_q, out_n_d;
  logic        out_err_q, out_err_d;

  logic        load_s;
  logic [15:0] res_s;
  logic        carry_s;
  logic        err_s;
  logic        rot_nz_s;
  logic        big_s;
  logic        in_range_s;
  logic [3:0]  idx_l_s;
  logic [3:0]  idx_r_s;

  // Shift-amount decode shared by all carry rules
  always_comb begin
    big_s      = amt_q[4];
    in_range_s = (amt_q != 5'd0) && (amt_q <= 5'd16);
    // 16-k and k-1 wrap naturally in 4 bits for k = 16
    idx_l_s    = 4'd0 - amt_q[3:0];
    idx_r_s    = amt_q[3:0] - 4'd1;
    rot_nz_s   = ((op_q == OP_ROL) || (op_q == OP_ROR)) && (amt_q[3:0] != 4'd0);
  end

  // Next-state, operand capture and result computation
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    amt_d     = amt_q;
    op_d      = op_q;
    partial_d = partial_q;
    sh_a_d    = sh_a_q;
    sh_sel_d  = sh_sel_q;
    sh_lr_d   = sh_lr_q;
    load_s    = 1'b0;
    res_s     = 16'd0;
    carry_s   = 1'b0;
    err_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.in_a;
          amt_d    = bus.in_amt;
          op_d     = bus.in_op;
          sh_a_d   = bus.in_a;
          sh_sel_d = bus.in_amt[3:0];
          sh_lr_d  = pass1_lr(bus.in_op);
          state_d  = PASS1;
        end else begin
          state_d  = IDLE;
        end
      end

      PASS1: begin
        if (rot_nz_s) begin
          partial_d = bus.sh_b;
          sh_lr_d   = (op_q == OP_ROL) ? LR_LR : LR_LL;
          sh_sel_d  = 4'd0 - amt_q[3:0];
          state_d   = PASS2;
        end else begin
          load_s  = 1'b1;
          state_d = DONE;
          case (op_q)
            OP_SLL: begin
              res_s   = big_s ? 16'h0000 : bus.sh_b;
              carry_s = in_range_s ? a_q[idx_l_s] : 1'b0;
            end
            OP_SRL: begin
              res_s   = big_s ? 16'h0000 : bus.sh_b;
              carry_s = in_range_s ? a_q[idx_r_s] : 1'b0;
            end
            OP_SRA: begin
              res_s   = big_s ? {16{a_q[15]}} : bus.sh_b;
              if (amt_q == 5'd0) begin
                carry_s = 1'b0;
              end else if (in_range_s) begin
                carry_s = a_q[idx_r_s];
              end else begin
                carry_s = a_q[15];
              end
            end
            OP_ROL, OP_ROR: begin
              res_s   = a_q;
              carry_s = 1'b0;
            end
            default: begin
              res_s   = a_q;
              carry_s = 1'b0;
              err_s   = 1'b1;
            end
          endcase
        end
      end

      PASS2: begin
        load_s  = 1'b1;
        res_s   = partial_q | bus.sh_b;
        carry_s = (op_q == OP_ROL) ? res_s[0] : res_s[15];
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    out_data_d = load_s ? res_s : out_data_q;
    out_c_d    = load_s ? carry_s : out_c_q;
    out_z_d    = load_s ? (res_s == 16'd0) : out_z_q;
    out_n_d    = load_s ? res_s[15] : out_n_q;
    out_err_d  = load_s ? err_s : out_err_q;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= 16'd0;
      amt_q      <= 5'd0;
      op_q       <= 3'd0;
      partial_q  <= 16'd0;
      sh_a_q     <= 16'd0;
      sh_sel_q   <= 4'd0;
      sh_lr_q    <= 2'd0;
      out_data_q <= 16'd0;
      out_c_q    <= 1'b0;
      out_z_q    <= 1'b0;
      out_n_q    <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      amt_q      <= amt_d;
      op_q       <= op_d;
      partial_q  <= partial_d;
      sh_a_q     <= sh_a_d;
      sh_sel_q   <= sh_sel_d;
      sh_lr_q    <= sh_lr_d;
      out_data_q <= out_data_d;
      out_c_q    <= out_c_d;
      out_z_q    <= out_z_d;
      out_n_q    <= out_n_d;
      out_err_q  <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sh_a      = sh_a_q;
  assign bus.sh_sel    = sh_sel_q;
  assign bus.sh_lr     = sh_lr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_n     = out_n_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_shift_seq_16b.sv
// Bench for shift_seq_16b: behavioural barrel shifter, directed plan cases and
// randomized operations compared against a wide-arithmetic reference model.
module tb_shift_seq_16b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  shift_seq_16b_if bus();

  shift_seq_16b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External combinational barrel shifter
  always_comb begin
    case (bus.sh_lr)
      2'b00:   bus.sh_b = bus.sh_a << bus.sh_sel;
      2'b10:   bus.sh_b = bus.sh_a >> bus.sh_sel;
      2'b11:   bus.sh_b = 16'($signed(bus.sh_a) >>> bus.sh_sel);
      default: bus.sh_b = 16'h0000;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: shifts as slices of wide shifted words, rotates as bit permutations
  task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [4:0] amt,
                           output logic [15:0] r, output logic c, output logic err);
    logic [31:0]        w;
    logic signed [47:0] s;
    int                 k;
    k   = amt % 16;
    err = 1'b0;
    case (op)
      3'd0: begin
        w = {16'h0000, a} << amt;
        r = w[15:0];
        c = w[16];
      end
      3'd1: begin
        w = {a, 16'h0000} >> amt;
        r = w[31:16];
        c = w[15];
      end
      3'd2: begin
        s = $signed({{16{a[15]}}, a, 16'h0000}) >>> amt;
        r = s[31:16];
        c = s[15];
      end
      3'd3: begin
        for (int i = 0; i < 16; i++) r[(i + k) % 16] = a[i];
        c = (k == 0) ? 1'b0 : r[0];
      end
      3'd4: begin
        for (int i = 0; i < 16; i++) r[(i + 16 - k) % 16] = a[i];
        c = (k == 0) ? 1'b0 : r[15];
      end
      default: begin
        r   = a;
        c   = 1'b0;
        err = 1'b1;
      end
    endcase
  endtask

  function automatic logic [1:0] exp_lr1(input logic [2:0] op);
    case (op)
      3'd2:       return 2'b11;
      3'd1, 3'd4: return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  // One complete operation: accept, pass checks, result, backpressure, release
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [4:0] amt,
                        input int hold);
    logic [15:0] er;
    logic        ec, ee;
    logic [3:0]  sel2;
    bit          rot_nz;
    int          waited;
    ref_model(op, a, amt, er, ec, ee);
    rot_nz = ((op == 3'd3) || (op == 3'd4)) && (amt[3:0] != 4'd0);
    sel2   = 4'd0 - amt[3:0];

    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_amt    = amt;
    bus.in_op     = op;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = (hold > 0);
    bus.in_a     = 16'($urandom);
    bus.in_amt   = 5'($urandom);
    bus.in_op    = 3'($urandom);

    check_eq("p1_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("p1_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("p1_sh_a", 32'(bus.sh_a), 32'(a));
    check_eq("p1_sh_sel", 32'(bus.sh_sel), 32'(amt[3:0]));
    if (op <= 3'd4) check_eq("p1_sh_lr", 32'(bus.sh_lr), 32'(exp_lr1(op)));
    if (rot_nz) begin
      @(negedge clk);
      check_eq("p2_sh_sel", 32'(bus.sh_sel), 32'(sel2));
      check_eq("p2_sh_lr", 32'(bus.sh_lr), (op == 3'd3) ? 32'd2 : 32'd0);
      check_eq("p2_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    waited = 0;
    while (!bus.out_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_eq("latency_extra", 32'(waited), 32'd0);
    check_eq("out_data", 32'(bus.out_data), 32'(er));
    check_eq("out_c", 32'(bus.out_c), 32'(ec));
    check_eq("out_z", 32'(bus.out_z), 32'(er == 16'd0));
    check_eq("out_n", 32'(bus.out_n), 32'(er[15]));
    check_eq("out_err", 32'(bus.out_err), 32'(ee));

    for (int i = 0; i < hold; i++) begin
      bus.in_a = 16'($urandom);
      @(negedge clk);
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_out_data", 32'(bus.out_data), 32'(er));
      check_eq("bp_out_flags", {28'd0, bus.out_c, bus.out_z, bus.out_n, bus.out_err},
               {28'd0, ec, (er == 16'd0), er[15], ee});
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check_eq("exit_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("exit_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  // Plan case with literal expectations on top of the model comparison
  task automatic plan_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [4:0] amt, input logic [15:0] exp_d, input logic exp_c,
                         input int hold);
    logic [15:0] got_d;
    logic        got_c;
    bus.out_ready = 1'b0;
    fork
      run_op(op, a, amt, hold);
      begin
        int guard = 0;
        while (!bus.out_valid && guard < 10) begin
          @(negedge clk);
          guard++;
        end
        got_d = bus.out_data;
        got_c = bus.out_c;
      end
    join
    check_eq({tag, "_data"}, 32'(got_d), 32'(exp_d));
    check_eq({tag, "_c"}, 32'(got_c), 32'(exp_c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0000;
    bus.in_amt    = 5'd0;
    bus.in_op     = 3'd0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_flags", {28'd0, bus.out_c, bus.out_z, bus.out_n, bus.out_err}, 32'd0);
    check_eq("rst_sh_port", {10'd0, bus.sh_a, bus.sh_sel, bus.sh_lr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    plan_op("sll_8001_1", 3'd0, 16'h8001, 5'd1, 16'h0002, 1'b1, 0);
    plan_op("sra_8000_4", 3'd2, 16'h8000, 5'd4, 16'hF800, 1'b0, 0);
    plan_op("sra_8000_20", 3'd2, 16'h8000, 5'd20, 16'hFFFF, 1'b1, 0);
    plan_op("srl_8000_16", 3'd1, 16'h8000, 5'd16, 16'h0000, 1'b1, 0);
    plan_op("sll_0001_17", 3'd0, 16'h0001, 5'd17, 16'h0000, 1'b0, 0);
    plan_op("rol_1234_4", 3'd3, 16'h1234, 5'd4, 16'h2341, 1'b1, 0);
    plan_op("ror_0001_1", 3'd4, 16'h0001, 5'd1, 16'h8000, 1'b1, 0);
    plan_op("rol_1234_16", 3'd3, 16'h1234, 5'd16, 16'h1234, 1'b0, 0);
    plan_op("bp_sll", 3'd0, 16'h00F0, 5'd3, 16'h0780, 1'b0, 5);
    plan_op("illegal_110", 3'd6, 16'hBEEF, 5'd7, 16'hBEEF, 1'b0, 2);

    // Reset while a rotate is in its second pass
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h1234;
    bus.in_amt   = 5'd4;
    bus.in_op    = 3'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_p2_sh_sel", 32'(bus.sh_sel), 32'd12);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("mid_rst_sh_sel", 32'(bus.sh_sel), 32'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_result", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;

    for (int n = 0; n < 200; n++) begin
      run_op(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
